sram_req_arbiter: RTL and testbench

// - Shares one sram-like memory port between an instruction-fetch requester (read-only) and the EXE-stage data requester.
// - Grants one requester at a time and latches its address, strobe and write data.
// - Drives the latched request to memory, then routes the single response back to the owner.
// - Sits between IF/EXE and the unified memory port; one outstanding transaction.

---
 rtl/sram_req_arbiter.sv | 119 +++++++++++
 tb/tb_sram_req_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like memory port between instruction fetch and the EXE data requester.
// One transaction at a time. The data requester has fixed priority, and the owner's response is routed back to it.
module sram_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                owner_data_reg, owner_data_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_data_reg <= 1'b0;
      addr_reg       <= '0;
      wstrb_reg      <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_data_reg <= owner_data_next;
      addr_reg       <= addr_next;
      wstrb_reg      <= wstrb_next;
      wdata_reg      <= wdata_next;
    end
  end

  // Requester inputs are only looked at in IDLE; the loser simply keeps holding its req.
  always_comb begin
    state_next      = state_reg;
    owner_data_next = owner_data_reg;
    addr_next       = addr_reg;
    wstrb_next      = wstrb_reg;
    wdata_next      = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (data_req) begin
          state_next      = REQ;
          owner_data_next = 1'b1;
          addr_next       = data_addr;
          wstrb_next      = data_wstrb;
          wdata_next      = data_wdata;
        end else if (inst_req) begin
          state_next      = REQ;
          owner_data_next = 1'b0;
          addr_next       = inst_addr;
          wstrb_next      = '0;
          wdata_next      = '0;
        end
      end
      REQ: begin
        if (mem_addr_ok) state_next = RESP;
      end
      RESP: begin
        if (mem_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // addr_ok is gated by reset so that every handshake output reads 0 while reset is held.
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    case (state_reg)
      IDLE: begin
        data_addr_ok = data_req & ~reset;
        inst_addr_ok = inst_req & ~data_req & ~reset;
      end
      REQ: mem_req = 1'b1;
      RESP: begin
        data_data_ok = mem_data_ok & owner_data_reg;
        inst_data_ok = mem_data_ok & ~owner_data_reg;
      end
      default: ;
    endcase
  end

  assign mem_addr   = addr_reg;
  assign mem_wstrb  = wstrb_reg;
  assign mem_wdata  = wdata_reg;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios plus randomized traffic.
// Each cycle is checked against a transaction-level model of one outstanding request.
module tb_sram_req_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0, data_req = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  sram_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: is a transaction in flight, has memory accepted it, and what was granted.
  bit          m_busy = 0, m_sent = 0, m_owner_data = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_wstrb = '0;

  task automatic step(input bit rs, input bit ir, input logic [31:0] ia,
                      input bit dr, input logic [3:0] ds, input logic [31:0] da,
                      input logic [31:0] dw, input bit maok, input bit mdok,
                      input logic [31:0] mrd, output bit g_inst, output bit g_data);
    bit idle, live, e_mreq, resp;
    @(posedge clk);
    #1;
    reset = rs; inst_req = ir; inst_addr = ia; data_req = dr; data_wstrb = ds;
    data_addr = da; data_wdata = dw; mem_addr_ok = maok; mem_data_ok = mdok;
    mem_rdata = mrd;
    @(negedge clk);
    if (rs) begin
      m_busy = 0; m_sent = 0; m_owner_data = 0;
      m_addr = '0; m_wstrb = '0; m_wdata = '0;
    end
    idle   = !m_busy && !rs;
    live   = m_busy && !rs;
    e_mreq = live && !m_sent;
    resp   = live && m_sent && mdok;
    g_data = idle && dr;
    g_inst = idle && ir && !dr;
    check("data_addr_ok", 64'(data_addr_ok), 64'(g_data));
    check("inst_addr_ok", 64'(inst_addr_ok), 64'(g_inst));
    check("mem_req", 64'(mem_req), 64'(e_mreq));
    check("data_data_ok", 64'(data_data_ok), 64'(resp && m_owner_data));
    check("inst_data_ok", 64'(inst_data_ok), 64'(resp && !m_owner_data));
    check("mem_addr", 64'(mem_addr), 64'(m_addr));
    check("mem_wstrb", 64'(mem_wstrb), 64'(m_wstrb));
    check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    if (resp && m_owner_data) check("data_rdata", 64'(data_rdata), 64'(mrd));
    if (resp && !m_owner_data) check("inst_rdata", 64'(inst_rdata), 64'(mrd));
    if (resp)
      $display("txn %s addr=%h wstrb=%h wdata=%h rdata=%h",
               m_owner_data ? "data" : "inst", m_addr, m_wstrb, m_wdata, mrd);
    if (g_data || g_inst) begin
      m_busy = 1; m_sent = 0; m_owner_data = g_data;
      m_addr  = g_data ? da : ia;
      m_wstrb = g_data ? ds : 4'h0;
      m_wdata = g_data ? dw : 32'h0;
    end else if (e_mreq && maok) begin
      m_sent = 1;
    end else if (resp) begin
      m_busy = 0;
    end
  endtask

  bit gi, gd;
  bit ip, dp;
  logic [31:0] ia, da, dw;
  logic [3:0]  ds;

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(1, 1, 32'h1, 1, 4'hF, 32'h2, 32'h3, 0, 1, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Fetch with addr_ok at cycle 1 and data_ok at cycle 3
    step(0, 1, 32'h1C000000, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h02800C21, gi, gd);

    // Collision: the store wins and the fetch stays held until the next IDLE
    step(0, 1, 32'h1C000004, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0, 0, gi, gd);
    step(0, 1, 32'h1C000004, 0, 0, 0, 0, 1, 0, 0, gi, gd);
    step(0, 1, 32'h1C000004, 0, 0, 0, 0, 0, 1, 32'h0, gi, gd);
    step(0, 1, 32'h1C000004, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, gi, gd);

    // Memory stall for 5 cycles while the other requester waits
    step(0, 0, 0, 1, 4'h3, 32'h400, 32'hCAFEF00D, 0, 0, 0, gi, gd);
    for (int k = 0; k < 5; k++)
      step(0, 1, 32'h1C000008, 1, 4'hC, 32'h500, 32'h1, 0, 0, 0, gi, gd);
    step(0, 1, 32'h1C000008, 0, 0, 0, 0, 1, 0, 0, gi, gd);
    step(0, 1, 32'h1C000008, 0, 0, 0, 0, 0, 1, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BADCAFE, gi, gd);

    // Spurious responses in IDLE, in REQ, and together with mem_addr_ok
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5, gi, gd);
    step(0, 0, 0, 1, 4'h0, 32'h203, 0, 0, 1, 32'h6, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8, gi, gd);
    // Byte load completes
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h000000AB, gi, gd);

    // Reset in RESP followed by a late response, then a normal grant
    step(0, 1, 32'h1C000010, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, gi, gd);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99, gi, gd);
    step(0, 0, 0, 1, 4'h1, 32'h600, 32'h77, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44, gi, gd);

    // Randomized traffic: requesters hold until granted, memory responds randomly
    ip = 0; dp = 0; ia = '0; da = '0; dw = '0; ds = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ia = $urandom;
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; da = $urandom; dw = $urandom;
        ds = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      step(($urandom_range(0, 99) == 0), ip, ia, dp, ds, da, dw,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, gi, gd);
      if (gi) ip = 0;
      if (gd) dp = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
